dca_matrix_mac_tile: RTL and testbench



---
 rtl/dca_matrix_mac_tile_pkg.sv | 8 +
 rtl/dca_matrix_mac_tile_sat.sv | 25 ++
 rtl/dca_matrix_mac_tile.sv | 104 ++++++++++
 tb/tb_dca_matrix_mac_tile.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dca_matrix_mac_tile_pkg.sv
// dca_matrix_mac_tile_pkg: shared FSM state encoding for the MAC tile
package dca_matrix_mac_tile_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/dca_matrix_mac_tile_sat.sv
// dca_matrix_mac_tile_sat: combinational clamp/truncate of one accumulator to BW_OUT
// Ports: acc (accumulator value), is_signed (two's complement view),
// saturate (1 clamp, 0 keep low BW_OUT bits), y (output element)
module dca_matrix_mac_tile_sat #(
  parameter int BW_ACC = 32,
  parameter int BW_OUT = 16
) (
  input  logic [BW_ACC-1:0] acc,
  input  logic              is_signed,
  input  logic              saturate,
  output logic [BW_OUT-1:0] y
);
  localparam logic [BW_ACC-1:0] U_MAX = {BW_ACC{1'b1}} >> (BW_ACC - BW_OUT);
  localparam logic [BW_ACC-1:0] S_MAX = U_MAX >> 1;
  localparam logic [BW_ACC-1:0] S_MIN = ~S_MAX;
  logic s_hi, s_lo, u_hi;
  always_comb begin
    s_hi = $signed(acc) > $signed(S_MAX);
    s_lo = $signed(acc) < $signed(S_MIN);
    u_hi = acc > U_MAX;
    y = !saturate ? acc[BW_OUT-1:0] :
        is_signed ? (s_hi ? S_MAX[BW_OUT-1:0] : s_lo ? S_MIN[BW_OUT-1:0] : acc[BW_OUT-1:0]) :
        (u_hi ? U_MAX[BW_OUT-1:0] : acc[BW_OUT-1:0]);
  end
endmodule

// File: rtl/dca_matrix_mac_tile.sv
// dca_matrix_mac_tile: NxN outer-product MAC tile with instruction, operand and row-drain streams
// Ports: clk/rstnn (async active-low); inst_* instruction handshake (k beats, mode bits);
// opnd_* operand handshake (A column, B row); out_* row stream (out_last on row N-1);
// busy (not idle), done (pulse after last row handshake)
module dca_matrix_mac_tile
  import dca_matrix_mac_tile_pkg::*;
#(
  parameter int MATRIX_SIZE = 4,
  parameter int BW_ELEM     = 8,
  parameter int BW_ACC      = 32,
  parameter int BW_OUT      = 16,
  parameter int BW_K        = 8
) (
  input  logic                           clk,
  input  logic                           rstnn,
  input  logic                           inst_valid,
  output logic                           inst_ready,
  input  logic [BW_K-1:0]                inst_k,
  input  logic                           inst_accumulate,
  input  logic                           inst_signed,
  input  logic                           inst_saturate,
  input  logic                           opnd_valid,
  output logic                           opnd_ready,
  input  logic [MATRIX_SIZE*BW_ELEM-1:0] opnd_a,
  input  logic [MATRIX_SIZE*BW_ELEM-1:0] opnd_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [MATRIX_SIZE*BW_OUT-1:0]  out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);
  localparam int N  = MATRIX_SIZE;
  localparam int RW = $clog2(N);
  state_t state, state_d;
  logic [BW_K-1:0] k_q, cnt;
  logic [RW-1:0] row;
  logic sgn_q, sat_q;
  logic [BW_ACC-1:0] acc [N][N];
  logic signed [2*BW_ELEM+1:0] prod [N][N];
  logic inst_fire, opnd_fire, out_fire, last_beat;
  always_comb begin
    inst_ready = state == IDLE;
    opnd_ready = state == LOAD;
    out_valid  = state == DRAIN;
    busy       = state != IDLE;
    out_last   = out_valid && row == RW'(N - 1);
    inst_fire  = inst_valid && inst_ready;
    opnd_fire  = opnd_valid && opnd_ready;
    out_fire   = out_valid && out_ready;
    last_beat  = opnd_fire && cnt == k_q - BW_K'(1);
    state_d    = state == IDLE ? (inst_fire ? (inst_k != '0 ? LOAD : DRAIN) : IDLE) :
                 state == LOAD ? (last_beat ? DRAIN : LOAD) :
                 (out_fire && out_last ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn) begin
      state <= IDLE;
      k_q   <= '0;
      cnt   <= '0;
      row   <= '0;
      sgn_q <= 1'b0;
      sat_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      done  <= out_fire && out_last;
      if (inst_fire) begin
        k_q   <= inst_k;
        sgn_q <= inst_signed;
        sat_q <= inst_saturate;
        cnt   <= '0;
      end else if (opnd_fire) cnt <= cnt + BW_K'(1);
      if (out_fire) row <= out_last ? '0 : row + RW'(1);
    end
  // Operands widened by one bit so a single signed multiply serves both modes.
  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      assign prod[i][j] =
        $signed({sgn_q & opnd_a[(i+1)*BW_ELEM-1], opnd_a[i*BW_ELEM +: BW_ELEM]}) *
        $signed({sgn_q & opnd_b[(j+1)*BW_ELEM-1], opnd_b[j*BW_ELEM +: BW_ELEM]});
    end
  end
  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] <= '0;
    end else if (inst_fire && !inst_accumulate) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] <= '0;
    end else if (opnd_fire) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++)
        acc[i][j] <= acc[i][j] + BW_ACC'(prod[i][j]);
    end
  // Output row is a pure function of held registers, so it cannot move while stalled.
  for (genvar j = 0; j < N; j++) begin : g_o
    logic [BW_OUT-1:0] y;
    dca_matrix_mac_tile_sat #(.BW_ACC(BW_ACC), .BW_OUT(BW_OUT)) u_sat (
      .acc(acc[row][j]),
      .is_signed(sgn_q),
      .saturate(sat_q),
      .y(y)
    );
    assign out_data[j*BW_OUT +: BW_OUT] = out_valid ? y : '0;
  end
endmodule

// File: tb/tb_dca_matrix_mac_tile.sv
// tb_dca_matrix_mac_tile: directed plus randomized checks of the MAC tile against a matrix model
module tb_dca_matrix_mac_tile;
  localparam int N = 4, BE = 8, BA = 32, BO = 16, BK = 8;
  logic clk = 1'b0, rstnn = 1'b0;
  logic inst_valid = 0, inst_ready, inst_accumulate = 0, inst_signed = 0, inst_saturate = 0;
  logic [BK-1:0] inst_k = '0;
  logic opnd_valid = 0, opnd_ready;
  logic [N*BE-1:0] opnd_a = '0, opnd_b = '0;
  logic out_valid, out_ready = 0, out_last, busy, done;
  logic [N*BO-1:0] out_data;
  int errors = 0, checks = 0;
  logic [BA-1:0] c_m [N][N];
  bit m_sgn, m_sat;

  dca_matrix_mac_tile #(.MATRIX_SIZE(N), .BW_ELEM(BE), .BW_ACC(BA), .BW_OUT(BO), .BW_K(BK)) dut (
    .clk(clk), .rstnn(rstnn), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_k(inst_k),
    .inst_accumulate(inst_accumulate), .inst_signed(inst_signed), .inst_saturate(inst_saturate),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BO-1:0] ref_out(logic [BA-1:0] v);
    longint sv = m_sgn ? longint'($signed(v)) : longint'(v);
    if (!m_sat) return v[BO-1:0];
    if (m_sgn) return sv > 32767 ? 16'h7fff : sv < -32768 ? 16'h8000 : v[BO-1:0];
    return sv > 65535 ? 16'hffff : v[BO-1:0];
  endfunction

  function automatic logic [N*BO-1:0] exp_row(int r);
    logic [N*BO-1:0] d;
    for (int j = 0; j < N; j++) d[j*BO +: BO] = ref_out(c_m[r][j]);
    return d;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) c_m[i][j] = '0;
  endtask

  task automatic inst(int k, bit acc, bit sg, bit st);
    int t = 0;
    inst_k = BK'(k); inst_accumulate = acc; inst_signed = sg; inst_saturate = st; inst_valid = 1;
    while (!inst_ready && t < 50) begin @(negedge clk); t++; end
    if (!inst_ready) chk("inst_wait", inst_ready, 1);
    @(negedge clk);
    inst_valid = 0;
    m_sgn = sg; m_sat = st;
    if (!acc) clear_model();
  endtask

  task automatic beat(logic [N*BE-1:0] a, logic [N*BE-1:0] b, int gaps);
    int t = 0;
    repeat (gaps) begin
      opnd_valid = 0; opnd_a = $urandom; opnd_b = $urandom;
      @(negedge clk);
      chk("opnd_ready_gap", opnd_ready, 1);
    end
    opnd_a = a; opnd_b = b; opnd_valid = 1;
    while (!opnd_ready && t < 50) begin @(negedge clk); t++; end
    if (!opnd_ready) chk("opnd_wait", opnd_ready, 1);
    @(negedge clk);
    opnd_valid = 0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      logic [BE-1:0] ai, bj;
      int p;
      ai = a[i*BE +: BE]; bj = b[j*BE +: BE];
      p = m_sgn ? int'($signed(ai)) * int'($signed(bj)) : int'(ai) * int'(bj);
      c_m[i][j] = c_m[i][j] + p;
    end
  endtask

  task automatic drain(int stall_row, int stall_n, bit poke);
    for (int r = 0; r < N; r++) begin
      int t = 0;
      logic [N*BO-1:0] held;
      out_ready = 0;
      while (!out_valid && t < 50) begin @(negedge clk); t++; end
      if (!out_valid) chk("out_wait", out_valid, 1);
      chk($sformatf("row%0d_data", r), out_data, exp_row(r));
      chk($sformatf("row%0d_last", r), out_last, r == N - 1);
      chk("busy_drain", busy, 1);
      chk("opnd_ready_drain", opnd_ready, 0);
      held = out_data;
      if (r == stall_row) repeat (stall_n) begin
        inst_valid = poke;
        @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held);
        chk("stall_last", out_last, r == N - 1);
        chk("stall_inst_ready", inst_ready, 0);
      end
      inst_valid = 0;
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("done_pulse", done, r == N - 1);
      if (r == N - 1) begin
        chk("idle_inst_ready", inst_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
        @(negedge clk);
        chk("done_clear", done, 0);
      end
    end
  endtask

  function automatic logic [N*BE-1:0] rep(logic [BE-1:0] x);
    return {N{x}};
  endfunction

  initial begin
    clear_model();
    #12;
    chk("rst_inst_ready", inst_ready, 1);
    chk("rst_opnd_ready", opnd_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rstnn = 1; @(negedge clk);
    // 1: unsigned outer product
    inst(1, 0, 0, 0);
    beat({8'd4, 8'd3, 8'd2, 8'd1}, rep(8'd1), 0);
    chk("t1_row0_const", out_data, 64'h0001_0001_0001_0001);
    drain(-1, 0, 0);
    // 2: signed -128*-128*4 saturated and truncated
    for (int s = 1; s >= 0; s--) begin
      inst(4, 0, 1, s[0]);
      repeat (4) beat(rep(8'h80), rep(8'h80), 0);
      chk("t2_row0_const", out_data, s ? 64'h7fff_7fff_7fff_7fff : 64'h0);
      drain(-1, 0, 0);
    end
    // 3: same bytes unsigned vs signed
    for (int s = 0; s < 2; s++) begin
      inst(2, 0, s[0], 1);
      repeat (2) beat(rep(8'hff), rep(8'hff), 0);
      chk("t3_row0_const", out_data, s ? 64'h0002_0002_0002_0002 : 64'hffff_ffff_ffff_ffff);
      drain(-1, 0, 0);
    end
    // 4: accumulate chain
    inst(1, 0, 0, 0); beat(rep(8'd1), rep(8'd1), 0); drain(-1, 0, 0);
    inst(1, 1, 0, 0); beat(rep(8'd1), rep(8'd1), 0);
    chk("t4_acc2", out_data, 64'h0002_0002_0002_0002);
    drain(-1, 0, 0);
    inst(0, 1, 0, 0);
    chk("t4_drain_only", out_data, 64'h0002_0002_0002_0002);
    drain(-1, 0, 0);
    inst(0, 0, 0, 0);
    chk("t4_cleared", out_data, 64'h0);
    drain(-1, 0, 0);
    // 5: operand gaps, output stall, instruction poke during drain
    inst(2, 0, 0, 0);
    beat(rep(8'd1), rep(8'd1), 0);
    beat(rep(8'd1), rep(8'd1), 2);
    chk("t5_two_beats", out_data, 64'h0002_0002_0002_0002);
    drain(1, 5, 1);
    // 6: reset mid-LOAD
    inst(4, 1, 0, 0);
    beat(rep(8'd3), rep(8'd5), 0);
    beat(rep(8'd3), rep(8'd5), 0);
    #2 rstnn = 0;
    #1;
    chk("mid_rst_inst_ready", inst_ready, 1);
    chk("mid_rst_opnd_ready", opnd_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    clear_model();
    @(negedge clk); rstnn = 1; @(negedge clk);
    inst(1, 1, 0, 0);
    beat(rep(8'd1), rep(8'd1), 0);
    chk("t6_after_rst", out_data, 64'h0001_0001_0001_0001);
    drain(-1, 0, 0);
    // randomized instructions
    for (int n = 0; n < 25; n++) begin
      int k;
      k = $urandom_range(0, 5);
      inst(k, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      for (int b = 0; b < k; b++) beat($urandom, $urandom, $urandom_range(0, 2));
      drain($urandom_range(0, N - 1), $urandom_range(0, 3), $urandom_range(0, 1));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
